// File: rtl/key_search_ctrl.sv
// key_search_ctrl: steps an RC4 decrypt core through the candidate keys
// KEY_FIRST..KEY_LAST. It stops on the first key the core reports as valid
// (FOUND) or after the last key misses (EXHAUSTED).
// Optional feature: define KEY_SEARCH_TIMEOUT_EN to add a WAIT watchdog. If
// the core goes silent, the watchdog treats the key as a miss and sets the
// sticky timeout_err flag.
// Timing: core_start pulses in the first WAIT cycle. This gives a 2-cycle
// gap from a missed core_done to the next core_start.

module key_search_ctrl #(
    parameter logic [23:0] KEY_FIRST      = 24'h000000,
    parameter logic [23:0] KEY_LAST       = 24'h3FFFFF,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        core_done,
    input  logic        core_found,
    output logic        core_start,
    output logic [23:0] secret_key,
    output logic        searching,
    output logic        found_key,
    output logic        not_found_key,
    output logic [23:0] keys_tried,
    output logic        timeout_err
);

    localparam int unsigned KEY_W = 24;
    localparam logic [KEY_W-1:0] CNT_MAX = {KEY_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT      = 3'd2,
        FOUND     = 3'd3,
        EXHAUSTED = 3'd4
    } state_t;

    state_t state;

    logic key_done_c;   // current key finished (answer or watchdog expiry)
    logic key_hit_c;    // current key finished and was the right one

    // Reject unusable parameter sets at elaboration.
    if (KEY_FIRST > KEY_LAST || TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("key_search_ctrl: need KEY_FIRST <= KEY_LAST and TIMEOUT_CYCLES > 0");
    end

`ifdef KEY_SEARCH_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_c;

    // Watchdog expires on the TIMEOUT_CYCLES-th WAIT cycle without an answer.
    always_comb begin
        timeout_c  = (state == WAIT) && !core_done && (wd_cnt == WD_LAST);
        key_done_c = (state == WAIT) && (core_done || timeout_c);
        key_hit_c  = (state == WAIT) && core_done && core_found;
    end

    // Watchdog counter: cleared on launch, counts while waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state == LAUNCH) begin
            wd_cnt <= '0;
        end else if (state == WAIT && !core_done && !timeout_c) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // Sticky timeout flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (timeout_c) begin
            timeout_err <= 1'b1;
        end
    end
`else
    // Without the watchdog, only a core answer ends WAIT.
    always_comb begin
        key_done_c = (state == WAIT) && core_done;
        key_hit_c  = (state == WAIT) && core_done && core_found;
    end

    assign timeout_err = 1'b0;
`endif

    // Search FSM with registered status, key and counter outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            secret_key    <= KEY_FIRST;
            keys_tried    <= '0;
            core_start    <= 1'b0;
            searching     <= 1'b0;
            found_key     <= 1'b0;
            not_found_key <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE, FOUND, EXHAUSTED: begin
                    if (start) begin
                        state         <= LAUNCH;
                        secret_key    <= KEY_FIRST;
                        keys_tried    <= '0;
                        searching     <= 1'b1;
                        found_key     <= 1'b0;
                        not_found_key <= 1'b0;
                    end
                end

                LAUNCH: begin
                    core_start <= 1'b1;
                    state      <= WAIT;
                end

                WAIT: begin
                    if (key_done_c) begin
                        keys_tried <= (keys_tried == CNT_MAX) ? keys_tried
                                                              : keys_tried + KEY_W'(1);
                        if (key_hit_c) begin
                            state     <= FOUND;
                            searching <= 1'b0;
                            found_key <= 1'b1;
                        end else if (secret_key == KEY_LAST) begin
                            state         <= EXHAUSTED;
                            searching     <= 1'b0;
                            not_found_key <= 1'b1;
                        end else begin
                            state      <= LAUNCH;
                            secret_key <= secret_key + KEY_W'(1);
                        end
                    end
                end

                default: begin
                    state         <= IDLE;
                    searching     <= 1'b0;
                    found_key     <= 1'b0;
                    not_found_key <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed bench for key_search_ctrl: full-range search, top-of-range
// exhaustion, ignored inputs, reset dominance and (with KEY_SEARCH_TIMEOUT_EN)
// the watchdog path.

module tb_key_search_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance A: default key range.
    logic        reset_a = 1'b1, start_a = 1'b0, core_done_a = 1'b0, core_found_a = 1'b0;
    logic        core_start_a, searching_a, found_key_a, not_found_key_a, timeout_err_a;
    logic [23:0] secret_key_a, keys_tried_a;

    // Instance B: two-key range at the top of the key space.
    logic        reset_b = 1'b1, start_b = 1'b0, core_done_b = 1'b0, core_found_b = 1'b0;
    logic        core_start_b, searching_b, found_key_b, not_found_key_b, timeout_err_b;
    logic [23:0] secret_key_b, keys_tried_b;

    key_search_ctrl dut_a (
        .clk           (clk),
        .reset         (reset_a),
        .start         (start_a),
        .core_done     (core_done_a),
        .core_found    (core_found_a),
        .core_start    (core_start_a),
        .secret_key    (secret_key_a),
        .searching     (searching_a),
        .found_key     (found_key_a),
        .not_found_key (not_found_key_a),
        .keys_tried    (keys_tried_a),
        .timeout_err   (timeout_err_a)
    );

    key_search_ctrl #(
        .KEY_FIRST (24'h3FFFFE),
        .KEY_LAST  (24'h3FFFFF)
    ) dut_b (
        .clk           (clk),
        .reset         (reset_b),
        .start         (start_b),
        .core_done     (core_done_b),
        .core_found    (core_found_b),
        .core_start    (core_start_b),
        .secret_key    (secret_key_b),
        .searching     (searching_b),
        .found_key     (found_key_b),
        .not_found_key (not_found_key_b),
        .keys_tried    (keys_tried_b),
        .timeout_err   (timeout_err_b)
    );

`ifdef KEY_SEARCH_TIMEOUT_EN
    // Instance T: short watchdog.
    logic        reset_t = 1'b1, start_t = 1'b0, core_done_t = 1'b0, core_found_t = 1'b0;
    logic        core_start_t, searching_t, found_key_t, not_found_key_t, timeout_err_t;
    logic [23:0] secret_key_t, keys_tried_t;

    key_search_ctrl #(
        .TIMEOUT_CYCLES (16)
    ) dut_t (
        .clk           (clk),
        .reset         (reset_t),
        .start         (start_t),
        .core_done     (core_done_t),
        .core_found    (core_found_t),
        .core_start    (core_start_t),
        .secret_key    (secret_key_t),
        .searching     (searching_t),
        .found_key     (found_key_t),
        .not_found_key (not_found_key_t),
        .keys_tried    (keys_tried_t),
        .timeout_err   (timeout_err_t)
    );
`endif

    // Advance one clock; returns 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt;

        // ---------------- reset state ----------------
        tick(); tick();
        reset_a = 1'b0; reset_b = 1'b0;
        chk("rst_key_a",      32'(secret_key_a), 32'h0);
        chk("rst_tried_a",    32'(keys_tried_a), 32'h0);
        chk("rst_start_a",    32'(core_start_a), 32'h0);
        chk("rst_search_a",   32'(searching_a), 32'h0);
        chk("rst_found_a",    32'(found_key_a), 32'h0);
        chk("rst_nf_a",       32'(not_found_key_a), 32'h0);
        chk("rst_tmo_a",      32'(timeout_err_a), 32'h0);
        chk("rst_key_b",      32'(secret_key_b), 32'h3FFFFE);

        // ---------------- core_done in IDLE ignored ----------------
        core_done_a = 1'b1; core_found_a = 1'b1;
        tick();
        core_done_a = 1'b0; core_found_a = 1'b0;
        chk("idle_done_found",  32'(found_key_a), 32'h0);
        chk("idle_done_search", 32'(searching_a), 32'h0);
        chk("idle_done_tried",  32'(keys_tried_a), 32'h0);
        tick();
        chk("idle_no_start",    32'(core_start_a), 32'h0);

        // ---------------- search A: found on key 3 ----------------
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("launch_search", 32'(searching_a), 32'h1);
        chk("launch_key",    32'(secret_key_a), 32'h0);
        chk("launch_nostrt", 32'(core_start_a), 32'h0);
        tick();
        chk("first_start",   32'(core_start_a), 32'h1);

        for (int k = 0; k < 4; k++) begin
            if (k == 1) start_a = 1'b1;          // start toggled in WAIT
            tick();
            start_a = 1'b0;
            chk("pulse_width",  32'(core_start_a), 32'h0);
            chk("key_stable",   32'(secret_key_a), 32'(k));
            chk("tried_stable", 32'(keys_tried_a), 32'(k));
            if (k == 0) begin
                repeat (20) tick();
                chk("wait_holds_key", 32'(secret_key_a), 32'h0);
                chk("wait_no_start",  32'(core_start_a), 32'h0);
                chk("wait_no_tmo",    32'(timeout_err_a), 32'h0);
            end
            core_done_a = 1'b1; core_found_a = (k == 3);
            tick();
            core_done_a = 1'b0; core_found_a = 1'b0;
            if (k < 3) begin
                chk("miss_next_key", 32'(secret_key_a), 32'(k + 1));
                chk("miss_tried",    32'(keys_tried_a), 32'(k + 1));
                chk("miss_gap1",     32'(core_start_a), 32'h0);
                chk("miss_search",   32'(searching_a), 32'h1);
                tick();
                chk("miss_gap2_start", 32'(core_start_a), 32'h1);
            end else begin
                chk("hit_found",  32'(found_key_a), 32'h1);
                chk("hit_key",    32'(secret_key_a), 32'h3);
                chk("hit_tried",  32'(keys_tried_a), 32'h4);
                chk("hit_search", 32'(searching_a), 32'h0);
                chk("hit_nf",     32'(not_found_key_a), 32'h0);
                chk("hit_nostrt", 32'(core_start_a), 32'h0);
            end
        end

        // ---------------- core_done in FOUND ignored ----------------
        core_done_a = 1'b1; core_found_a = 1'b0;
        tick();
        core_done_a = 1'b0;
        chk("found_done_found", 32'(found_key_a), 32'h1);
        chk("found_done_key",   32'(secret_key_a), 32'h3);
        chk("found_done_tried", 32'(keys_tried_a), 32'h4);
        repeat (3) begin
            tick();
            chk("found_no_start", 32'(core_start_a), 32'h0);
        end

        // ---------------- restart from FOUND, then reset mid-WAIT ----------------
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("restart_key",    32'(secret_key_a), 32'h0);
        chk("restart_tried",  32'(keys_tried_a), 32'h0);
        chk("restart_found",  32'(found_key_a), 32'h0);
        chk("restart_search", 32'(searching_a), 32'h1);
        tick();
        chk("restart_start",  32'(core_start_a), 32'h1);
        tick(); tick();
        reset_a = 1'b1; core_done_a = 1'b1; core_found_a = 1'b1;
        tick();
        reset_a = 1'b0; core_done_a = 1'b0; core_found_a = 1'b0;
        chk("rstwait_found",  32'(found_key_a), 32'h0);
        chk("rstwait_search", 32'(searching_a), 32'h0);
        chk("rstwait_key",    32'(secret_key_a), 32'h0);
        chk("rstwait_tried",  32'(keys_tried_a), 32'h0);
        tick();
        chk("rstwait_idle_found",  32'(found_key_a), 32'h0);
        chk("rstwait_idle_nostrt", 32'(core_start_a), 32'h0);

        // ---------------- search B: exhaust 3FFFFE..3FFFFF ----------------
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        tick();
        chk("b_start0",  32'(core_start_b), 32'h1);
        chk("b_key0",    32'(secret_key_b), 32'h3FFFFE);
        tick();
        core_done_b = 1'b1;
        tick();
        core_done_b = 1'b0;
        chk("b_key1",    32'(secret_key_b), 32'h3FFFFF);
        chk("b_tried1",  32'(keys_tried_b), 32'h1);
        tick();
        chk("b_start1",  32'(core_start_b), 32'h1);
        tick();
        core_done_b = 1'b1;
        tick();
        core_done_b = 1'b0;
        chk("b_nf",      32'(not_found_key_b), 32'h1);
        chk("b_found",   32'(found_key_b), 32'h0);
        chk("b_key_end", 32'(secret_key_b), 32'h3FFFFF);
        chk("b_tried2",  32'(keys_tried_b), 32'h2);
        chk("b_search",  32'(searching_b), 32'h0);
        chk("b_tmo",     32'(timeout_err_b), 32'h0);
        core_done_b = 1'b1;
        tick();
        core_done_b = 1'b0;
        chk("b_exh_tried", 32'(keys_tried_b), 32'h2);
        repeat (3) begin
            tick();
            chk("b_exh_no_start", 32'(core_start_b), 32'h0);
        end

`ifdef KEY_SEARCH_TIMEOUT_EN
        // ---------------- watchdog: key 0 silent, key 1 found ----------------
        tick();
        reset_t = 1'b0;
        start_t = 1'b1;
        tick();
        start_t = 1'b0;
        tick();
        chk("t_start0", 32'(core_start_t), 32'h1);
        cnt = 0;
        while (secret_key_t != 24'h1 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("t_latency", 32'(cnt), 32'd16);
        chk("t_err",     32'(timeout_err_t), 32'h1);
        chk("t_tried1",  32'(keys_tried_t), 32'h1);
        tick();
        chk("t_start1",  32'(core_start_t), 32'h1);
        tick();
        core_done_t = 1'b1; core_found_t = 1'b1;
        tick();
        core_done_t = 1'b0; core_found_t = 1'b0;
        chk("t_found",   32'(found_key_t), 32'h1);
        chk("t_key",     32'(secret_key_t), 32'h1);
        chk("t_tried2",  32'(keys_tried_t), 32'h2);
        chk("t_err_sticky", 32'(timeout_err_t), 32'h1);
        chk("t_nf",      32'(not_found_key_t), 32'h0);
        chk("t_search",  32'(searching_t), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
